// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and controller states.
package cp0_pkg;

  // CP0 register indices as seen by mfc0/mtc0 (WB_rd)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // ExcCode values written into Cause[6:2]
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_DZ  = 5'd7;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Exception/eret sequencing: detect in IDLE, pulse flush in FLUSH, settle in DRAIN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt lines.
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let both flops sample the old values, forming a real two-stage chain.
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/wb_cp0_ctrl.sv
// CP0 controller at the WB stage: Status/Cause/EPC, exception and eret sequencing,
// pipeline flush and PC redirect generation.
module wb_cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_opcplus4,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_instruction,
  input  logic        WB_Eret,
  input  logic        WB_Mfc0,
  input  logic        WB_Mtc0,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_rt_value,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc
);

  cp0_state_e  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        is_exc_q, is_exc_d;   // 1: redirect to handler, 0: redirect to EPC (eret)

  logic [5:0]  ext_int_sync;
  logic        sync_exc;
  logic        irq;
  logic        take_exc;
  logic        take_eret;
  logic        do_mtc0;
  logic [4:0]  exc_code;

  // mfc0 reads the operand bus directly, so the flag itself carries no information here
  logic        unused_mfc0;
  assign unused_mfc0 = WB_Mfc0;

  int_sync #(.W(6)) u_int_sync (
    .clk    (clock),
    .rst_n  (reset),
    .async_i(ext_int),
    .sync_o (ext_int_sync)
  );

  // Exception detection and fixed-priority ExcCode selection
  always_comb begin
    sync_exc = WB_Reserved_instruction | WB_Overflow | WB_Divide_zero | WB_Syscall | WB_Break;
    irq      = (|(cause_q[15:8] & status_q[15:8])) & status_q[0] & ~status_q[1];
    if      (WB_Reserved_instruction) exc_code = EXC_RI;
    else if (WB_Overflow)             exc_code = EXC_OV;
    else if (WB_Divide_zero)          exc_code = EXC_DZ;
    else if (WB_Syscall)              exc_code = EXC_SYS;
    else if (WB_Break)                exc_code = EXC_BP;
    else                              exc_code = EXC_INT;
    take_exc  = (state_q == ST_IDLE) && (sync_exc || irq);
    take_eret = (state_q == ST_IDLE) && WB_Eret && !take_exc;
    do_mtc0   = (state_q == ST_IDLE) && WB_Mtc0 && !take_exc && !WB_Eret;
  end

  // Next-state and CP0 register update logic
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d            = state_q;
    status_d           = status_q;
    cause_d            = cause_q;
    epc_d              = epc_q;
    is_exc_d           = is_exc_q;
    cause_d[15:10]     = ext_int_sync;

    unique case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          cause_d[6:2] = exc_code;
          status_d[1]  = 1'b1;
          if (!status_q[1]) epc_d = sync_exc ? WB_PC : WB_opcplus4;
          is_exc_d     = 1'b1;
          state_d      = ST_FLUSH;
        end else if (take_eret) begin
          status_d[1]  = 1'b0;
          is_exc_d     = 1'b0;
          state_d      = ST_FLUSH;
        end else if (do_mtc0) begin
          case (WB_rd)
            CP0_STATUS: status_d       = WB_rt_value;
            CP0_CAUSE:  cause_d[9:8]   = WB_rt_value[9:8];
            CP0_EPC:    epc_d          = WB_rt_value;
            default:    ;
          endcase
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and architectural register flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
      is_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      is_exc_q <= is_exc_d;
    end
  end

  // Flush/redirect decoded from state so reset drops them at once
  always_comb begin
    flush          = (state_q == ST_FLUSH);
    redirect_valid = flush;
    redirect_pc    = '0;
    if (flush) redirect_pc = is_exc_q ? EXC_VECTOR : epc_q;
  end

  // mfc0 read port, selected by WB_rd regardless of the mfc0 flag
  always_comb begin
    case (WB_rd)
      CP0_STATUS: cp0_rdata = status_q;
      CP0_CAUSE:  cp0_rdata = cause_q;
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = '0;
    endcase
  end

  assign cp0_status = status_q;
  assign cp0_cause  = cause_q;
  assign cp0_epc    = epc_q;

endmodule
